// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory-side responder of the 16-bit datapath.
package mem_if_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and a registered read port.
// The array itself has no reset so its contents survive a responder reset.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              rd_zero_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // rd_zero_i lets the owner return zero for reads it has judged out of range.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Memory responder: latches a MAR/MDR request, waits LATENCY cycles, completes the
// access and signals MFC with a four-phase handshake against MemRead/MemWrite.
module main_memory_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              MFC,
    output logic              Busy,
    output logic              Err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              isWrite_q, isWrite_d;
    logic              mfc_q, mfc_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              inRange;
    logic              ramWe, ramRe;

    // Range is judged on the full address; only the low bits reach the array.
    assign inRange = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            isWrite_q <= 1'b0;
            mfc_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            isWrite_q <= isWrite_d;
            mfc_q     <= mfc_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        isWrite_d = isWrite_q;
        mfc_d     = mfc_q;
        busy_d    = busy_q;
        err_d     = 1'b0;
        ramWe     = 1'b0;
        ramRe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemRead ^ MemWrite) begin
                    addr_d    = Addr;
                    wdata_d   = WData;
                    isWrite_d = MemWrite;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    busy_d    = 1'b1;
                    state_d   = ACCESS;
                end else if (MemRead && MemWrite) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    ramWe   = isWrite_q && inRange;
                    ramRe   = !isWrite_q;
                    mfc_d   = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = !inRange;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Leaving DONE never accepts a request, guaranteeing an IDLE cycle.
                if (!MemRead && !MemWrite) begin
                    mfc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (IDX_W)
    ) u_mem (
        .clk_i     (Clk),
        .rst_ni    (Reset_n),
        .we_i      (ramWe),
        .re_i      (ramRe),
        .rd_zero_i (!inRange),
        .addr_i    (addr_q[IDX_W-1:0]),
        .wdata_i   (wdata_q),
        .rdata_o   (RData)
    );

    assign MFC  = mfc_q;
    assign Busy = busy_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: a LATENCY=3 instance for most traffic and a
// LATENCY=1 instance for the single-cycle case; completions checked via a scoreboard.
module tb_main_memory_responder;

    typedef struct {
        bit          isWr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expR;
        logic        expE;
    } vecT;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN3, rd3, wr3, mfc3, busy3, err3;
    logic [15:0] addr3, wdata3, rdata3;
    logic        rstN1, rd1, wr1, mfc1, busy1, err1;
    logic [15:0] addr1, wdata1, rdata1;

    int  checks   = 0;
    int  failures = 0;
    expT sb[$];
    vecT vecs[8];

    main_memory_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(3)) dut3 (
        .Clk(clk), .Reset_n(rstN3), .MemRead(rd3), .MemWrite(wr3), .Addr(addr3),
        .WData(wdata3), .RData(rdata3), .MFC(mfc3), .Busy(busy3), .Err(err3)
    );

    main_memory_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(1)) dut1 (
        .Clk(clk), .Reset_n(rstN1), .MemRead(rd1), .MemWrite(wr1), .Addr(addr1),
        .WData(wdata1), .RData(rdata1), .MFC(mfc1), .Busy(busy1), .Err(err1)
    );

    function automatic logic getMfc(input bit f);
        return f ? mfc1 : mfc3;
    endfunction

    function automatic logic getBusy(input bit f);
        return f ? busy1 : busy3;
    endfunction

    function automatic logic getErr(input bit f);
        return f ? err1 : err3;
    endfunction

    function automatic logic [15:0] getRData(input bit f);
        return f ? rdata1 : rdata3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit f, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (f) begin
            rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end else begin
            rd3 = r; wr3 = w; addr3 = a; wdata3 = d;
        end
    endtask

    // One full transaction: drive, accept, count edges to MFC, compare, then release.
    task automatic applyStimulus(input bit f, input bit isWr, input logic [15:0] a,
                                 input logic [15:0] d, input logic [15:0] expR,
                                 input logic expE, input bit earlyDrop);
        expT e;
        int  n;
        int  lat;
        lat = f ? 1 : 3;
        e.rdata = expR;
        e.err   = expE;
        sb.push_back(e);
        @(negedge clk);
        drive(f, !isWr, isWr, a, d);
        @(posedge clk); #1;
        checkOutput("busy_accept", 32'(getBusy(f)), 32'd1);
        checkOutput("mfc_accept", 32'(getMfc(f)), 32'd0);
        if (earlyDrop) drive(f, 1'b0, 1'b0, a, d);
        n = 0;
        while (!getMfc(f) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("mfc_latency", 32'(n), 32'(lat));
        e = sb.pop_front();
        checkOutput("rdata", 32'(getRData(f)), 32'(e.rdata));
        checkOutput("err_at_mfc", 32'(getErr(f)), 32'(e.err));
        checkOutput("busy_at_mfc", 32'(getBusy(f)), 32'd0);
        if (!earlyDrop) begin
            @(posedge clk); #1;
            checkOutput("mfc_hold", 32'(getMfc(f)), 32'd1);
            drive(f, 1'b0, 1'b0, a, d);
        end
        @(posedge clk); #1;
        checkOutput("mfc_release", 32'(getMfc(f)), 32'd0);
        checkOutput("err_release", 32'(getErr(f)), 32'd0);
        checkOutput("rdata_hold", 32'(getRData(f)), 32'(e.rdata));
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0000, 16'h0F0F, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b1, 16'h0007, 16'h00AA, 16'hBEEF, 1'b0};
        vecs[4] = '{1'b0, 16'h0007, 16'h0000, 16'h00AA, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0};
        vecs[6] = '{1'b1, 16'h03FF, 16'h7777, 16'h0F0F, 1'b0};
        vecs[7] = '{1'b0, 16'h03FF, 16'h0000, 16'h7777, 1'b0};

        rstN3 = 1'b0; rstN1 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rdata", 32'(rdata3), 32'h0);
        checkOutput("reset_mfc", 32'(mfc3), 32'd0);
        checkOutput("reset_busy", 32'(busy3), 32'd0);
        checkOutput("reset_err", 32'(err3), 32'd0);
        @(negedge clk);
        rstN3 = 1'b1; rstN1 = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].isWr, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expR, vecs[i].expE, 1'b0);
        end

        $display("[TB] both read and write asserted");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'hDEAD);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("both_err", 32'(err3), 32'd1);
            checkOutput("both_busy", 32'(busy3), 32'd0);
            checkOutput("both_mfc", 32'(mfc3), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0005, 16'hDEAD);
        @(posedge clk); #1;
        checkOutput("both_err_clear", 32'(err3), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0005, 16'h0, 16'hBEEF, 1'b0, 1'b0);

        $display("[TB] out of range");
        applyStimulus(1'b0, 1'b0, 16'h0400, 16'h0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0400, 16'h1234, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0, 16'h0F0F, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0, 16'h0F0F, 1'b0, 1'b0);

        $display("[TB] reset during access");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 16'h0007, 16'h5555);
        @(posedge clk); #1;
        checkOutput("rst_busy_before", 32'(busy3), 32'd1);
        @(posedge clk); #1;
        rstN3 = 1'b0;
        #1;
        checkOutput("rst_mfc", 32'(mfc3), 32'd0);
        checkOutput("rst_busy", 32'(busy3), 32'd0);
        checkOutput("rst_err", 32'(err3), 32'd0);
        checkOutput("rst_rdata", 32'(rdata3), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0007, 16'h5555);
        @(negedge clk);
        rstN3 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_idle_mfc", 32'(mfc3), 32'd0);
        checkOutput("rst_idle_busy", 32'(busy3), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0007, 16'h0, 16'h00AA, 1'b0, 1'b0);

        $display("[TB] early request drop");
        applyStimulus(1'b0, 1'b0, 16'h0005, 16'h0, 16'hBEEF, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h03FF, 16'h0, 16'h7777, 1'b0, 1'b1);

        $display("[TB] latency one");
        applyStimulus(1'b1, 1'b1, 16'h0005, 16'h1111, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0400, 16'h0, 16'h0000, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
